// File: rtl/div_arb_pkg.sv
// Shared types for div_arbiter: FSM state encoding, requester-count limits and
// a one-hot to binary index helper.
package div_arb_pkg;

  localparam int unsigned NREQ_MAX = 8;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    WAIT,
    RESP
  } arb_state_e;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NREQ_MAX; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin selector: searches last+1 .. last+NREQ (mod NREQ)
// and grants the first pending request. Holds no state.
module rr_pick
  import div_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int unsigned         slot;
  logic [NREQ_MAX-1:0] gnt_ext;

  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    slot  = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      slot = 32'(last_i) + k;
      if (slot >= NREQ) slot = slot - NREQ;
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!any_o && (slot == j) && req_i[j]) begin
          gnt_o[j] = 1'b1;
          any_o    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_ext            = '0;
    gnt_ext[NREQ-1:0]  = gnt_o;
  end

  assign idx_o = onehot_to_idx(gnt_ext);

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sequencer sharing one divider among NREQ requesters.
// Optional feature macro: DIV_ZERO_CHECK_EN (answer B==0 locally without the divider).
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   ReqValid,
  input  logic [NREQ*W-1:0] ReqA,
  input  logic [NREQ*W-1:0] ReqB,
  output logic [NREQ-1:0]   ReqReady,
  output logic [NREQ-1:0]   RspValid,
  output logic [W-1:0]      RspQ,
  output logic [W-1:0]      RspR,
  output logic              RspErr,
  output logic [W-1:0]      DivA,
  output logic [W-1:0]      DivB,
  output logic              DivStart,
  input  logic [W-1:0]      DivDQ,
  input  logic [W-1:0]      DivDR,
  input  logic              DivDone
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [NREQ-1:0]  win_q, win_d;
  logic [NREQ-1:0]  rdy_q, rdy_d;
  logic [NREQ-1:0]  rsp_vld_q, rsp_vld_d;
  logic [W-1:0]     div_a_q, div_a_d;
  logic [W-1:0]     div_b_q, div_b_d;
  logic [W-1:0]     rsp_q_q, rsp_q_d;
  logic [W-1:0]     rsp_r_q, rsp_r_d;
  logic             start_q, start_d;
`ifdef DIV_ZERO_CHECK_EN
  logic             err_q, err_d;
  logic             zero_q, zero_d;
`endif

  logic [NREQ-1:0]  pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [W-1:0]     sel_a, sel_b;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req_i (ReqValid),
    .last_i(last_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        sel_a = ReqA[i*W +: W];
        sel_b = ReqB[i*W +: W];
      end
    end
  end

  // Every output is registered, so each pulse appears one cycle after the
  // state that decides it (ReqReady in ISSUE, DivStart in ARM, RspValid in RESP).
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    rsp_q_d   = rsp_q_q;
    rsp_r_d   = rsp_r_q;
    rdy_d     = '0;
    rsp_vld_d = '0;
    start_d   = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
    err_d     = err_q;
    zero_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          last_d  = pick_idx;
          win_d   = pick_gnt;
          div_a_d = sel_a;
          div_b_d = sel_b;
          rdy_d   = pick_gnt;
          state_d = ISSUE;
`ifdef DIV_ZERO_CHECK_EN
          if (sel_b == '0) begin
            zero_d  = 1'b1;
            state_d = RESP;
          end
`endif
        end
      end
      ISSUE: begin
        start_d = 1'b1;
        state_d = ARM;
      end
      ARM: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (DivDone) begin
          rsp_vld_d = win_q;
          rsp_q_d   = DivDQ;
          rsp_r_d   = DivDR;
`ifdef DIV_ZERO_CHECK_EN
          err_d     = 1'b0;
`endif
          state_d   = RESP;
        end
      end
      RESP: begin
`ifdef DIV_ZERO_CHECK_EN
        // Divide-by-zero shortcut: the response leaves one cycle after ReqReady.
        if (zero_q) begin
          rsp_vld_d = win_q;
          rsp_q_d   = '1;
          rsp_r_d   = div_a_q;
          err_d     = 1'b1;
        end
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      last_q    <= IDX_W'(NREQ - 1);
      win_q     <= '0;
      rdy_q     <= '0;
      rsp_vld_q <= '0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      rsp_q_q   <= '0;
      rsp_r_q   <= '0;
      start_q   <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      err_q     <= 1'b0;
      zero_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      rdy_q     <= rdy_d;
      rsp_vld_q <= rsp_vld_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      rsp_q_q   <= rsp_q_d;
      rsp_r_q   <= rsp_r_d;
      start_q   <= start_d;
`ifdef DIV_ZERO_CHECK_EN
      err_q     <= err_d;
      zero_q    <= zero_d;
`endif
    end
  end

  assign ReqReady = rdy_q;
  assign RspValid = rsp_vld_q;
  assign RspQ     = rsp_q_q;
  assign RspR     = rsp_r_q;
  assign DivA     = div_a_q;
  assign DivB     = div_b_q;
  assign DivStart = start_q;
`ifdef DIV_ZERO_CHECK_EN
  assign RspErr   = err_q;
`else
  assign RspErr   = 1'b0;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural divider of adjustable
// latency; a scoreboard pairs each acceptance with its response.
module tb_div_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [W-1:0]      rsp_q, rsp_r, div_a, div_b, div_dq, div_dr;
  logic              rsp_err, div_start, div_done;

  always #5 clk = ~clk;

  div_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .Clk     (clk),
    .Reset   (rst),
    .ReqValid(req_valid),
    .ReqA    (req_a),
    .ReqB    (req_b),
    .ReqReady(req_ready),
    .RspValid(rsp_valid),
    .RspQ    (rsp_q),
    .RspR    (rsp_r),
    .RspErr  (rsp_err),
    .DivA    (div_a),
    .DivB    (div_b),
    .DivStart(div_start),
    .DivDQ   (div_dq),
    .DivDR   (div_dr),
    .DivDone (div_done)
  );

  // Behavioural divider: Done rises div_lat cycles after the first WAIT cycle.
  int unsigned div_lat = 0;
  int unsigned m_cnt;
  logic [W-1:0] m_q, m_r;
  logic         m_done;
  assign div_dq   = m_q;
  assign div_dr   = m_r;
  assign div_done = m_done;

  always @(posedge clk) begin
    if (rst) begin
      m_done <= 1'b0; m_cnt <= 0; m_q <= '0; m_r <= '0;
    end else begin
      m_done <= 1'b0;
      if (div_start) begin
        m_q <= (div_b == 0) ? 8'hFF : div_a / div_b;
        m_r <= (div_b == 0) ? div_a : div_a % div_b;
        if (div_lat == 0) m_done <= 1'b1;
        else m_cnt <= div_lat;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_done <= 1'b1;
      end
    end
  end

  typedef struct { int idx; logic [W-1:0] q; logic [W-1:0] r; logic err; } exp_t;
  typedef struct { int idx; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] q; logic [W-1:0] r; int lat; } vec_t;

  exp_t sb[$];
  int   order_q[$];
  int   n_vec = 0, n_bad = 0;
  int   cyc = 0, n_acc = 0, n_rsp = 0, n_start = 0, last_rdy_cyc = -100;
  logic [W-1:0] acc_a, acc_b;
  exp_t mon_e;

  function automatic void chk(string name, longint act, longint req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int oh2i(logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (req_ready != '0) begin
        chk("rdy_onehot", $countones(req_ready), 1);
        for (int j = 0; j < NREQ; j++) begin
          if (req_ready[j]) begin
            acc_a      = req_a[j*W +: W];
            acc_b      = req_b[j*W +: W];
            mon_e.idx  = j;
            mon_e.q    = (acc_b == 0) ? 8'hFF : acc_a / acc_b;
            mon_e.r    = (acc_b == 0) ? acc_a : acc_a % acc_b;
            mon_e.err  = (acc_b == 0) && ZCHK;
            sb.push_back(mon_e);
            order_q.push_back(j);
          end
        end
        n_acc++;
        last_rdy_cyc = cyc;
      end
      if (div_start) begin
        n_start++;
        chk("start_after_rdy", cyc - last_rdy_cyc, 1);
        chk("div_a", div_a, acc_a);
        chk("div_b", div_b, acc_b);
      end
      if (rsp_valid != '0) begin
        n_rsp++;
        if (sb.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_lane", oh2i(rsp_valid), mon_e.idx);
          chk("rsp_q", rsp_q, mon_e.q);
          chk("rsp_r", rsp_r, mon_e.r);
          chk("rsp_err", rsp_err, mon_e.err);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < NREQ; i++) begin
      if (i == lane) begin
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
      end
    end
  endtask

  task automatic wait_rdy(input logic [1:0] lane, input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (req_ready[lane]) begin
        t = cyc;
        req_valid[lane] = 1'b0;
        break;
      end
    end
    if (t < 0) begin
      chk("rdy_timeout", 0, 1);
      req_valid[lane] = 1'b0;
    end
  endtask

  task automatic wait_rsp(input logic [1:0] lane, input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (rsp_valid[lane]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("rsp_timeout", 0, 1);
  endtask

  task automatic run_mask(input logic [NREQ-1:0] mask, input bit hold, input int target, input int budget);
    int a0, r0;
    bit done;
    a0 = n_acc; r0 = n_rsp; done = 1'b0;
    req_valid = req_valid | mask;
    for (int k = 0; k < budget && !done; k++) begin
      tick();
      if (!hold) req_valid = req_valid & ~req_ready;
      if (n_acc - a0 >= target) req_valid = req_valid & ~mask;
      if ((n_acc - a0 >= target) && (n_rsp - r0 >= n_acc - a0)) done = 1'b1;
    end
    if (!done) begin
      chk("run_timeout", n_rsp - r0, target);
      req_valid = req_valid & ~mask;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    order_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ReqReady"}, req_ready, 0);
    chk({tag, "_RspValid"}, rsp_valid, 0);
    chk({tag, "_RspQ"}, rsp_q, 0);
    chk({tag, "_RspR"}, rsp_r, 0);
    chk({tag, "_RspErr"}, rsp_err, 0);
    chk({tag, "_DivA"}, div_a, 0);
    chk({tag, "_DivB"}, div_b, 0);
    chk({tag, "_DivStart"}, div_start, 0);
  endtask

  vec_t vt[6];
  int   fexp[6];

  initial begin
    int t_rdy, t_rsp, t_mark, s0, r0, exp_lat;
    bit zpath;

    vt[0] = '{1, 8'd50,  8'd3,   8'd16,  8'd2,  0};
    vt[1] = '{0, 8'd200, 8'd10,  8'd20,  8'd0,  3};
    vt[2] = '{2, 8'd7,   8'd9,   8'd0,   8'd7,  1};
    vt[3] = '{3, 8'd255, 8'd1,   8'd255, 8'd0,  5};
    vt[4] = '{1, 8'd1,   8'd255, 8'd0,   8'd1,  2};
    vt[5] = '{1, 8'd42,  8'd0,   8'd255, 8'd42, 2};
    fexp  = '{0, 1, 2, 3, 0, 1};

    // Reset state
    do_reset();
    check_zero_outputs("reset");

    // Contention straight after reset: requester 0 has priority
    div_lat = 1;
    set_lane(0, 8'd100, 8'd7);
    set_lane(2, 8'd9, 8'd4);
    run_mask(4'b0101, 1'b0, 2, 80);
    if (order_q.size() >= 2) begin
      chk("contend_first", order_q[0], 0);
      chk("contend_second", order_q[1], 2);
    end else begin
      chk("contend_count", order_q.size(), 2);
    end
    chk("contend_last_q", rsp_q, 2);
    chk("contend_last_r", rsp_r, 1);

    // Fairness: all requests held continuously
    do_reset();
    div_lat = 0;
    set_lane(0, 8'd100, 8'd7);
    set_lane(1, 8'd50, 8'd3);
    set_lane(2, 8'd9, 8'd4);
    set_lane(3, 8'd255, 8'd16);
    run_mask(4'b1111, 1'b1, 6, 200);
    for (int i = 0; i < 6; i++) begin
      if (i < order_q.size()) chk("fair_order", order_q[i], fexp[i]);
      else chk("fair_missing", i, -1);
    end

    // Table of single requests, including divide by zero
    for (int v = 0; v < 6; v++) begin
      div_lat = vt[v].lat;
      zpath   = (vt[v].b == 0) && ZCHK;
      exp_lat = zpath ? 1 : 3 + vt[v].lat;
      s0      = n_start;
      set_lane(vt[v].idx, vt[v].a, vt[v].b);
      req_valid[vt[v].idx] = 1'b1;
      wait_rdy(2'(vt[v].idx), 10, t_rdy);
      if (t_rdy >= 0) begin
        wait_rsp(2'(vt[v].idx), 40, t_rsp);
        if (t_rsp >= 0) begin
          chk("vec_latency", t_rsp - t_rdy, exp_lat);
          chk("vec_q", rsp_q, vt[v].q);
          chk("vec_r", rsp_r, vt[v].r);
          chk("vec_err", rsp_err, zpath);
          chk("vec_starts", n_start - s0, zpath ? 0 : 1);
        end
      end
      repeat (2) tick();
    end

    // Back-to-back: requester 3 re-requests in its RspValid cycle
    div_lat = 2;
    set_lane(3, 8'd60, 8'd7);
    req_valid[3] = 1'b1;
    wait_rdy(2'd3, 10, t_rdy);
    wait_rsp(2'd3, 40, t_mark);
    chk("b2b_first_q", rsp_q, 8);
    chk("b2b_first_r", rsp_r, 4);
    set_lane(3, 8'd255, 8'd16);
    req_valid[3] = 1'b1;
    wait_rdy(2'd3, 10, t_rdy);
    chk("b2b_gap", t_rdy - t_mark, 2);
    wait_rsp(2'd3, 40, t_rsp);
    chk("b2b_q", rsp_q, 15);
    chk("b2b_r", rsp_r, 15);

    // Reset while the divider is busy
    repeat (2) tick();
    div_lat = 12;
    set_lane(1, 8'd30, 8'd4);
    req_valid[1] = 1'b1;
    wait_rdy(2'd1, 10, t_rdy);
    repeat (4) tick();
    r0 = n_rsp;
    rst = 1'b1;
    tick();
    check_zero_outputs("midwait");
    rst = 1'b0;
    repeat (20) tick();
    chk("abort_no_rsp", n_rsp - r0, 0);

    order_q.delete();
    div_lat = 1;
    set_lane(2, 8'd200, 8'd10);
    set_lane(0, 8'd81, 8'd9);
    run_mask(4'b0101, 1'b0, 2, 80);
    if (order_q.size() >= 2) begin
      chk("post_rst_first", order_q[0], 0);
      chk("post_rst_second", order_q[1], 2);
    end else begin
      chk("post_rst_count", order_q.size(), 2);
    end
    chk("post_rst_q", rsp_q, 20);
    chk("post_rst_r", rsp_r, 0);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors, expected completion", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
